// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned FIFO_DEPTH    = 16;
   localparam int unsigned DEF_MAX_BURST = 4;
   localparam int unsigned BEAT_W        = 4;
   localparam int unsigned XFER_W        = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first valid requester strictly after last_id, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    last_id,
   output logic               found,
   output logic [ID_W-1:0]    next_id
);

   logic [ID_W:0]    w_idx;
   logic [NUM_REQ-1:0] w_shift;

   always_comb begin
      found   = 1'b0;
      next_id = '0;
      w_idx   = '0;
      w_shift = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         // last_id + k stays below 2*NUM_REQ, so one conditional subtract is the modulo
         w_idx = {1'b0, last_id} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(NUM_REQ))
            w_idx = w_idx - (ID_W+1)'(NUM_REQ);
         w_shift = req_valid >> w_idx;
         if (!found && w_shift[0]) begin
            found   = 1'b1;
            next_id = w_idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ producers into one FIFO write port.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        fifo_full,
   output logic                        fifo_wr,
   output logic [DATA_W-1:0]           fifo_din,
   output logic                        grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic [XFER_W-1:0]           xfer_cnt
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   state_t            r_state;
   state_t            w_next_state;
   logic [ID_W-1:0]   r_grant_id;
   logic [ID_W-1:0]   r_last_id;
   logic [BEAT_W-1:0] r_beat_cnt;
   logic [XFER_W-1:0] r_xfer_cnt;

   logic              w_found;
   logic [ID_W-1:0]   w_next_id;
   logic              w_gv;
   logic              w_sel_valid;
   logic              w_wr;
   logic              w_last_beat;
   logic              w_exit;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req_valid (req_valid),
      .last_id   (r_last_id),
      .found     (w_found),
      .next_id   (w_next_id)
   );

   assign w_gv        = (r_state == GRANT);
   assign w_sel_valid = req_valid[r_grant_id];
   assign w_wr        = w_gv & w_sel_valid & ~fifo_full;
   assign w_last_beat = (r_beat_cnt == BEAT_W'(MAX_BURST - 1));
   // A stalled grant (fifo_full) with the producer still valid is held indefinitely
   assign w_exit      = w_gv & (~w_sel_valid | (w_wr & w_last_beat));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_found) w_next_state = GRANT;
         GRANT:   if (w_exit)  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_grant_id <= '0;
         r_last_id  <= ID_W'(NUM_REQ - 1);
         r_beat_cnt <= '0;
         r_xfer_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_xfer_cnt <= r_xfer_cnt + XFER_W'(w_wr);
         if (r_state == IDLE) begin
            if (w_found) r_grant_id <= w_next_id;
         end else if (w_exit) begin
            r_beat_cnt <= '0;
            r_last_id  <= r_grant_id;
         end else if (w_wr) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (w_gv) req_ready[r_grant_id] = ~fifo_full;
   end

   assign fifo_wr     = w_wr;
   assign fifo_din    = w_gv ? req_data[r_grant_id*DATA_W +: DATA_W] : '0;
   assign grant_valid = w_gv;
   assign grant_id    = r_grant_id;
   assign xfer_cnt    = r_xfer_cnt;

endmodule
